neopixel_animator: RTL and testbench

NEOPIXEL_ANIMATOR -- requirements
Module: neopixel_animator

---
 rtl/neopixel_animator.sv | 150 +++++++++++++++
 tb/tb_neopixel_animator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/neopixel_animator.sv
// Rainbow/solid NeoPixel frame writer: one pixel word per cycle, first write the cycle after the frame tick.
// No backpressure: writes stream without gaps; a tick that lands on a busy frame is dropped and flagged.
module neopixel_animator #(
   parameter int          C_PIXELS    = 12,
   parameter int          C_FREQ_HZ   = 125000000,
   parameter int          C_FRAME_HZ  = 50,
   parameter logic [7:0]  C_HUE_STEP  = 8'd21,
   parameter logic [7:0]  C_HUE_SPEED = 8'd1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        mode,
   input  logic [23:0] solid_color,
   input  logic [2:0]  brightness,
   output logic        write_readf,
   output logic [31:0] address,
   output logic [31:0] write_data,
   output logic        busy,
   output logic        frame_done,
   output logic        overrun
);

   localparam int C_FRAME_CYCLES = C_FREQ_HZ / C_FRAME_HZ;
   localparam int TW = (C_FRAME_CYCLES > 1) ? $clog2(C_FRAME_CYCLES) : 1;
   localparam int PW = (C_PIXELS > 1) ? $clog2(C_PIXELS) : 1;

   typedef enum logic {IDLE, WRITE} state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] timer;
   logic          tick;
   logic [PW-1:0] pix_idx, pix_nxt;
   logic [7:0]    base_hue, hue, hue_nxt;
   logic          mode_q;
   logic [23:0]   color_q;
   logic [2:0]    bright_q;
   logic          start, load, last;
   logic          src_mode;
   logic [23:0]   src_color, pix_color, pix_shift;
   logic [2:0]    src_bright;

   function automatic logic [23:0] wheel(input logic [7:0] h);
      logic [7:0] k3;
      if (h < 8'd85) begin
         k3 = h * 8'd3;
         return {8'd255 - k3, k3, 8'd0};
      end else if (h < 8'd170) begin
         k3 = (h - 8'd85) * 8'd3;
         return {8'd0, 8'd255 - k3, k3};
      end else begin
         k3 = (h - 8'd170) * 8'd3;
         return {k3, 8'd0, 8'd255 - k3};
      end
   endfunction

   assign tick = (timer == TW'(C_FRAME_CYCLES - 1));
   assign last = (pix_idx == PW'(C_PIXELS - 1));
   assign busy = write_readf;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         timer <= '0;
      end else if (tick) begin
         timer <= '0;
      end else begin
         timer <= timer + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // The frame_done cycle is treated as still busy, so a tick there cannot start a frame.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      load      = 1'b0;
      pix_nxt   = pix_idx;
      hue_nxt   = hue;
      case (state)
         IDLE: begin
            if (tick && enable && !frame_done) begin
               start     = 1'b1;
               load      = 1'b1;
               state_nxt = WRITE;
               pix_nxt   = '0;
               hue_nxt   = base_hue;
            end
         end
         WRITE: begin
            if (last) begin
               state_nxt = IDLE;
               pix_nxt   = '0;
            end else begin
               load    = 1'b1;
               pix_nxt = pix_idx + 1'b1;
               hue_nxt = hue + C_HUE_STEP;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pixel 0 is built from the live inputs on the start edge; later pixels use the latched copy.
   always_comb begin
      src_mode   = start ? mode        : mode_q;
      src_color  = start ? solid_color : color_q;
      src_bright = start ? brightness  : bright_q;
      pix_color  = src_mode ? src_color : wheel(hue_nxt);
      pix_shift  = {pix_color[23:16] >> src_bright,
                    pix_color[15:8]  >> src_bright,
                    pix_color[7:0]   >> src_bright};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pix_idx     <= '0;
         hue         <= '0;
         base_hue    <= '0;
         mode_q      <= 1'b0;
         color_q     <= '0;
         bright_q    <= '0;
         write_readf <= 1'b0;
         address     <= '0;
         write_data  <= '0;
         frame_done  <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         pix_idx     <= pix_nxt;
         hue         <= hue_nxt;
         write_readf <= load;
         frame_done  <= (state == WRITE) && last;
         if ((state == WRITE) && last) base_hue <= base_hue + C_HUE_SPEED;
         if (start) begin
            mode_q   <= mode;
            color_q  <= solid_color;
            bright_q <= brightness;
         end
         if (load) begin
            address    <= 32'(pix_nxt);
            write_data <= {8'd0, pix_shift};
         end
         if (tick && ((state == WRITE) || frame_done)) overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_neopixel_animator.sv
// Directed bench for neopixel_animator: table-driven frames plus enable-drop, overrun and reset sequences.
module tb_neopixel_animator;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        mode = 1'b0;
   logic [23:0] solid_color = '0;
   logic [2:0]  brightness = '0;

   logic        write_readf, busy, frame_done, overrun;
   logic [31:0] address, write_data;
   logic        big_wr, big_busy, big_fd, big_ov;
   logic [31:0] big_addr, big_data;

   int checks = 0;
   int errors = 0;
   bit big_finished = 0;
   logic [31:0] frame_dat [12];

   always #5 clock = ~clock;

   neopixel_animator #(.C_PIXELS(12), .C_FREQ_HZ(1000), .C_FRAME_HZ(10)) dut (
      .clock(clock), .reset(reset), .enable(enable), .mode(mode),
      .solid_color(solid_color), .brightness(brightness),
      .write_readf(write_readf), .address(address), .write_data(write_data),
      .busy(busy), .frame_done(frame_done), .overrun(overrun));

   neopixel_animator #(.C_PIXELS(120), .C_FREQ_HZ(1000), .C_FRAME_HZ(10)) dut_big (
      .clock(clock), .reset(reset), .enable(enable), .mode(mode),
      .solid_color(solid_color), .brightness(brightness),
      .write_readf(big_wr), .address(big_addr), .write_data(big_data),
      .busy(big_busy), .frame_done(big_fd), .overrun(big_ov));

   typedef struct {
      logic        m;
      logic [23:0] col;
      logic [2:0]  br;
      bit          disturb;
      logic [31:0] p0, p1, p5, p11;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic wait_write(output bit ok);
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (write_readf) begin
            ok = 1;
            break;
         end
      end
   endtask

   // Captures one 12-write frame; at write drop_at, enable drops and (optionally) frame inputs change.
   task automatic capture_frame(input string nm, input int drop_at, input bit disturb);
      bit ok;
      int gaps = 0;
      wait_write(ok);
      chk({nm, " start"}, 32'(ok), 32'd1);
      if (!ok) return;
      for (int j = 0; j < 12; j++) begin
         if (j > 0) @(negedge clock);
         if (j == drop_at) enable = 1'b0;
         if (disturb && j == 3) begin
            mode = 1'b1;
            brightness = 3'd5;
            solid_color = 24'hFFFFFF;
         end
         if (!(write_readf && busy && address == 32'(j))) gaps++;
         frame_dat[j] = write_data;
      end
      chk({nm, " strobes"}, 32'(gaps), 32'd0);
      @(negedge clock);
      chk({nm, " done"}, {29'd0, write_readf, busy, frame_done}, 32'd1);
      @(negedge clock);
      chk({nm, " done_pulse"}, {31'd0, frame_done}, 32'd0);
   endtask

   // Long-frame instance: a tick lands mid-frame, is dropped, and the frame still completes.
   initial begin
      bit seen = 0;
      int n = 0;
      int gaps = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clock);
         if (!reset && big_wr) seen = 1;
      end
      chk("big start", 32'(seen), 32'd1);
      if (seen) begin
         chk("big overrun_before", {31'd0, big_ov}, 32'd0);
         for (int i = 0; i < 300; i++) begin
            if (!big_wr) break;
            if (big_addr != 32'(n)) gaps++;
            n++;
            @(negedge clock);
         end
         chk("big count", 32'(n), 32'd120);
         chk("big addr_seq", 32'(gaps), 32'd0);
         chk("big frame_done", {31'd0, big_fd}, 32'd1);
         chk("big overrun", {31'd0, big_ov}, 32'd1);
      end
      big_finished = 1;
   end

   initial begin
      bit ok;
      int cnt;

      vecs[0] = '{1'b0, 24'h0, 3'd0, 1'b0, 32'h00FF0000, 32'h00C03F00, 32'h0000C33C, 32'h00B70048};
      vecs[1] = '{1'b0, 24'h0, 3'd1, 1'b0, 32'h007E0100, 32'h005E2100, 32'h0000601F, 32'h005D0022};
      vecs[2] = '{1'b1, 24'h123456, 3'd2, 1'b0, 32'h00040D15, 32'h00040D15, 32'h00040D15, 32'h00040D15};
      vecs[3] = '{1'b0, 24'h0, 3'd0, 1'b1, 32'h00F60900, 32'h00B74800, 32'h0000BA45, 32'h00C0003F};
      vecs[4] = '{1'b0, 24'h0, 3'd7, 1'b0, 32'h00010000, 32'h00010000, 32'h00000100, 32'h00010000};

      repeat (2) @(negedge clock);
      chk("reset flags", {28'd0, write_readf, busy, frame_done, overrun}, 32'd0);
      chk("reset address", address, 32'd0);
      chk("reset data", write_data, 32'd0);
      reset = 1'b0;

      for (int v = 0; v < 5; v++) begin
         mode = vecs[v].m;
         solid_color = vecs[v].col;
         brightness = vecs[v].br;
         enable = 1'b1;
         capture_frame($sformatf("frame%0d", v), -1, vecs[v].disturb);
         chk($sformatf("frame%0d p0", v), frame_dat[0], vecs[v].p0);
         chk($sformatf("frame%0d p1", v), frame_dat[1], vecs[v].p1);
         chk($sformatf("frame%0d p5", v), frame_dat[5], vecs[v].p5);
         chk($sformatf("frame%0d p11", v), frame_dat[11], vecs[v].p11);
         chk($sformatf("frame%0d overrun", v), {31'd0, overrun}, 32'd0);
      end

      mode = 1'b0;
      brightness = 3'd0;
      enable = 1'b1;
      capture_frame("enable_drop", 2, 1'b0);
      cnt = 0;
      for (int i = 0; i < 210; i++) begin
         @(negedge clock);
         if (write_readf || frame_done) cnt++;
      end
      chk("idle after drop", 32'(cnt), 32'd0);

      for (int i = 0; i < 400 && !big_finished; i++) @(negedge clock);
      chk("big monitor finished", 32'(big_finished), 32'd1);

      enable = 1'b1;
      wait_write(ok);
      chk("reset_frame start", 32'(ok), 32'd1);
      repeat (4) @(negedge clock);
      chk("reset_frame at 5th write", {write_readf, 31'(address)}, {1'b1, 31'd4});
      reset = 1'b1;
      #1;
      chk("mid reset flags", {28'd0, write_readf, busy, frame_done, overrun}, 32'd0);
      chk("mid reset big_overrun", {31'd0, big_ov}, 32'd0);
      chk("mid reset address", address, 32'd0);
      chk("mid reset data", write_data, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      cnt = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         cnt++;
         if (write_readf) break;
      end
      chk("restart latency", 32'(cnt), 32'd100);
      chk("restart addr0", address, 32'd0);
      chk("restart data0", write_data, 32'h00FF0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
